kbd_event_decoder: RTL
======================

# kbd_event_decoder

Consumes the raw byte stream from the PS/2 keyboard receiver's FIFO and turns it into key events: make/break with E0 extension, held-key tracking, ASCII translation and a BCD key-press counter. Sits directly downstream of `ps2_keyboard` and drives the LED/seven-segment display path (`bcd7seg` digits and `ledr`). One byte per handshake, no buffering beyond the receiver's FIFO.

## Interface
- `IGNORE_REPEAT`, 1: when 1, typematic repeat makes of the held key do not pulse `key_valid` and do not count.
- `clk` in 1: system clock, same as `ps2_keyboard`.
- `resetn` in 1: asynchronous, active-low reset.
- `ps2_data` in 8: head-of-FIFO byte from the receiver, valid while `ps2_ready`=1.
- `ps2_ready` in 1: FIFO non-empty.
- `ps2_overflow` in 1: receiver FIFO overflow flag.
- `ps2_nextdata_n` out 1: active-low pop request, one cycle per consumed byte.
- `key_valid` out 1: one-cycle pulse per decoded make or break event.
- `key_break` out 1: qualifies `key_valid`; 1 = release, 0 = press.
- `key_ext` out 1: event carried an E0 prefix.
- `key_code` out 8: scan code of the last event.
- `key_ascii` out 8: ASCII of the last event; 0x00 if unmapped or extended.
- `key_held` out 1: a key is currently down (display enable).
- `press_bcd` out 8: two-digit BCD count of distinct presses.
- `overflow_seen` out 1: sticky, set when `ps2_overflow` is sampled high.

## Operation
- Byte FSM states: IDLE, PREFIX_E0, PREFIX_F0, PREFIX_E0F0, POP.
- In any non-POP state with `ps2_ready`=1: latch `ps2_data`, go to POP. POP drives `ps2_nextdata_n`=0 for exactly one cycle, ignores `ps2_ready`, then moves to the prefix state chosen from the latched byte.
- Transitions on the latched byte: 0xE0 from IDLE goes to PREFIX_E0. 0xF0 from IDLE goes to PREFIX_F0. 0xF0 from PREFIX_E0 goes to PREFIX_E0F0. Repeated 0xF0 in PREFIX_F0 or PREFIX_E0F0 keeps the state. 0xE0 in any prefix state restarts at PREFIX_E0. Any other byte is a code: emit event, return to IDLE.
- Event: `key_break`=1 from PREFIX_F0/PREFIX_E0F0. `key_ext`=1 from PREFIX_E0/PREFIX_E0F0. `key_code`=byte, `key_ascii`=lookup.
- Held tracking holds a single key as `{ext,code}`:
  - A make sets it and sets `key_held`.
  - A make equal to the held key while `key_held`=1 is a repeat. It is suppressed per `IGNORE_REPEAT`, but event registers still update.
  - A break matching the held key clears `key_held`. A non-matching break only produces an event.
- `press_bcd` increments on every non-repeat make. Low digit wraps 9→0 with carry; 99→00.
- ASCII map (non-extended only):
  - 0x1C→0x61 'a', 0x32→0x62 'b', the remaining letters per the standard set-2 map, lowercase.
  - 0x45→0x30 and 0x16→0x31 through 0x46→0x39 (set-2 digit row).
  - 0x29→0x20, 0x5A→0x0D, 0x66→0x08. Everything else →0x00.
- `overflow_seen` is cleared only by reset. Decoding continues while it is set.

## Timing
- Reset values: `ps2_nextdata_n`=1, `key_valid`=0, `key_break`=0, `key_ext`=0, `key_code`=0x00, `key_ascii`=0x00, `key_held`=0, `press_bcd`=0x00, `overflow_seen`=0, FSM=IDLE.
- Byte sampled at the edge ending cycle N. In cycle N+1: `ps2_nextdata_n`=0, event outputs and `press_bcd` updated, `key_valid`=1 (code bytes only). The next byte can be sampled in cycle N+2, so throughput is 2 cycles per byte.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-sequence (e.g. after F0) drops all prefix state. The first code after reset decodes as a make.

## Structure
- Shared package `kbd_pkg`: FSM state enum, constants `SC_E0`=0xE0, `SC_F0`=0xF0, ASCII constants.
- Sub-module `scancode_to_ascii`: purely combinational 8→8 case ROM. It is instantiated once, and its output is registered in the parent.

## Test plan
- Bytes 1C, F0, 1C (`ps2_ready` held) → `key_valid` pulses twice: make code 0x1C ascii 0x61 `key_held`=1, then break `key_held`=0; `press_bcd`=0x01; each byte popped by exactly one `ps2_nextdata_n` low cycle.
- Bytes E0, 75, E0, F0, 75 → make `key_ext`=1 code 0x75 ascii 0x00, then break `key_ext`=1; `press_bcd` 0x00→0x01.
- Bytes 1C, 1C, 1C, F0, 1C with `IGNORE_REPEAT`=1 → two `key_valid` pulses total, `press_bcd`=0x01; with `IGNORE_REPEAT`=0 → four pulses, count still 0x01.
- 100 make/break pairs of 0x29 → `press_bcd` reaches 0x99 then wraps to 0x00, with 0x09→0x10 carry checked.
- Byte F0, `resetn` pulsed low asynchronously mid-cycle, then byte 32 → all outputs at reset values during reset; event is make 0x32 ascii 0x62.
- `ps2_overflow` pulsed high one cycle → `overflow_seen`=1 and held; subsequent 1C decodes normally.

Source files
------------

// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared types, scan-code constants and BCD helper for the keyboard event decoder
package kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFIX_E0,
    ST_PREFIX_F0,
    ST_PREFIX_E0F0,
    ST_POP
  } kbd_state_e;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;

  localparam logic [7:0] ASC_NUL   = 8'h00;
  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_SPACE = 8'h20;

  // Two-digit BCD increment; 99 rolls over to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = (v[7:4] == 4'd9) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/scancode_to_ascii.sv
// rtl/scancode_to_ascii.sv - combinational set-2 scan code to lowercase ASCII ROM
module scancode_to_ascii
  import kbd_pkg::*;
(
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASC_NUL;
    case (code)
      8'h1C: ascii = 8'h61;
      8'h32: ascii = 8'h62;
      8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64;
      8'h24: ascii = 8'h65;
      8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67;
      8'h33: ascii = 8'h68;
      8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A;
      8'h42: ascii = 8'h6B;
      8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D;
      8'h31: ascii = 8'h6E;
      8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70;
      8'h15: ascii = 8'h71;
      8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73;
      8'h2C: ascii = 8'h74;
      8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76;
      8'h1D: ascii = 8'h77;
      8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79;
      8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30;
      8'h16: ascii = 8'h31;
      8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;
      8'h25: ascii = 8'h34;
      8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;
      8'h3D: ascii = 8'h37;
      8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = ASC_SPACE;
      8'h5A: ascii = ASC_CR;
      8'h66: ascii = ASC_BS;
      default: ascii = ASC_NUL;
    endcase
  end

endmodule

// File: rtl/kbd_event_decoder.sv
// rtl/kbd_event_decoder.sv - PS/2 byte stream to make/break key events, held key, ASCII and BCD press count
module kbd_event_decoder
  import kbd_pkg::*;
#(
  parameter bit IGNORE_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] ps2_data,
  input  logic       ps2_ready,
  input  logic       ps2_overflow,
  output logic       ps2_nextdata_n,
  output logic       key_valid,
  output logic       key_break,
  output logic       key_ext,
  output logic [7:0] key_code,
  output logic [7:0] key_ascii,
  output logic       key_held,
  output logic [7:0] press_bcd,
  output logic       overflow_seen
);

  kbd_state_e state_q, state_d, after_pop_q, after_pop_d;
  logic       nextdata_n_q, nextdata_n_d;
  logic       valid_q, valid_d;
  logic       break_q, break_d;
  logic       ext_q, ext_d;
  logic [7:0] code_q, code_d;
  logic [7:0] ascii_q, ascii_d;
  logic       held_q, held_d;
  logic       held_ext_q, held_ext_d;
  logic [7:0] held_code_q, held_code_d;
  logic [7:0] bcd_q, bcd_d;
  logic       ovf_q, ovf_d;

  logic [7:0] rom_ascii;
  logic       is_break, is_ext, same_key, is_repeat;

  scancode_to_ascii u_rom (
    .code  (ps2_data),
    .ascii (rom_ascii)
  );

  always_comb begin
    state_d      = state_q;
    after_pop_d  = after_pop_q;
    nextdata_n_d = 1'b1;
    valid_d      = 1'b0;
    break_d      = break_q;
    ext_d        = ext_q;
    code_d       = code_q;
    ascii_d      = ascii_q;
    held_d       = held_q;
    held_ext_d   = held_ext_q;
    held_code_d  = held_code_q;
    bcd_d        = bcd_q;
    ovf_d        = ovf_q | ps2_overflow;

    is_break  = (state_q == ST_PREFIX_F0) || (state_q == ST_PREFIX_E0F0);
    is_ext    = (state_q == ST_PREFIX_E0) || (state_q == ST_PREFIX_E0F0);
    same_key  = ({is_ext, ps2_data} == {held_ext_q, held_code_q});
    is_repeat = !is_break && held_q && same_key;

    if (state_q == ST_POP) begin
      state_d = after_pop_q;
    end else if (ps2_ready) begin
      // Decode now so every event output is registered alongside the pop strobe.
      state_d      = ST_POP;
      nextdata_n_d = 1'b0;
      if (ps2_data == SC_E0) begin
        after_pop_d = ST_PREFIX_E0;
      end else if (ps2_data == SC_F0) begin
        case (state_q)
          ST_IDLE:      after_pop_d = ST_PREFIX_F0;
          ST_PREFIX_E0: after_pop_d = ST_PREFIX_E0F0;
          default:      after_pop_d = state_q;
        endcase
      end else begin
        after_pop_d = ST_IDLE;
        break_d     = is_break;
        ext_d       = is_ext;
        code_d      = ps2_data;
        ascii_d     = is_ext ? ASC_NUL : rom_ascii;
        valid_d     = !(is_repeat && IGNORE_REPEAT);
        if (is_break) begin
          if (same_key) held_d = 1'b0;
        end else begin
          held_d      = 1'b1;
          held_ext_d  = is_ext;
          held_code_d = ps2_data;
          if (!is_repeat) bcd_d = bcd_inc(bcd_q);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      after_pop_q  <= ST_IDLE;
      nextdata_n_q <= 1'b1;
      valid_q      <= 1'b0;
      break_q      <= 1'b0;
      ext_q        <= 1'b0;
      code_q       <= 8'h00;
      ascii_q      <= 8'h00;
      held_q       <= 1'b0;
      held_ext_q   <= 1'b0;
      held_code_q  <= 8'h00;
      bcd_q        <= 8'h00;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      after_pop_q  <= after_pop_d;
      nextdata_n_q <= nextdata_n_d;
      valid_q      <= valid_d;
      break_q      <= break_d;
      ext_q        <= ext_d;
      code_q       <= code_d;
      ascii_q      <= ascii_d;
      held_q       <= held_d;
      held_ext_q   <= held_ext_d;
      held_code_q  <= held_code_d;
      bcd_q        <= bcd_d;
      ovf_q        <= ovf_d;
    end
  end

  assign ps2_nextdata_n = nextdata_n_q;
  assign key_valid      = valid_q;
  assign key_break      = break_q;
  assign key_ext        = ext_q;
  assign key_code       = code_q;
  assign key_ascii      = ascii_q;
  assign key_held       = held_q;
  assign press_bcd      = bcd_q;
  assign overflow_seen  = ovf_q;

endmodule
